// File: rtl/conf_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conf_reg_bank                                                |
// | Description : CONF-port write buffer (FIFO) feeding NUM_REGS config        |
// |               registers, with commit lock, per-register update strobes,   |
// |               sticky out-of-range error and optional registered readback   |
// |               (enabled by defining CONF_READBACK_EN).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conf_reg_bank #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 32,
    parameter int NUM_REGS     = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_ADDR_WIDTH-1:0]           c_addr,
    input  logic [C_DATA_WIDTH-1:0]           c_data,
    input  logic                              c_valid,
    output logic                              c_ready,
    input  logic                              cfg_lock,
    input  logic                              err_clr,
    output logic [NUM_REGS*C_DATA_WIDTH-1:0]  cfg_regs,
    output logic [NUM_REGS-1:0]               cfg_update,
    output logic                              c_err
`ifdef CONF_READBACK_EN
    ,
    input  logic [C_ADDR_WIDTH-1:0]           rd_addr,
    output logic [C_DATA_WIDTH-1:0]           rd_data
`endif
);

    localparam int                    c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                    c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]    c_FULL     = c_CNT_W'(FIFO_DEPTH);
    // One extra bit so NUM_REGS == 2**C_ADDR_WIDTH is still representable
    localparam logic [C_ADDR_WIDTH:0] c_NUM_REGS = (C_ADDR_WIDTH + 1)'(NUM_REGS);

    logic [C_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [C_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_err;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_in_range;
    logic [C_ADDR_WIDTH-1:0] w_head_addr;
    logic [C_DATA_WIDTH-1:0] w_head_data;

    assign c_ready     = !rst && (r_count != c_FULL);
    assign w_push      = c_valid && c_ready;
    assign w_pop       = (r_count != '0) && !cfg_lock;
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_in_range  = ({1'b0, w_head_addr} < c_NUM_REGS);
    assign c_err       = r_err;

    // Storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= c_addr;
            r_fifo_data[r_wr_ptr] <= c_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_pop && !w_in_range)
            r_err <= 1'b1;
        else if (err_clr)
            r_err <= 1'b0;
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            logic [C_DATA_WIDTH-1:0] r_reg;
            logic                    r_upd;
            logic                    w_hit;

            assign w_hit = w_pop && w_in_range && (w_head_addr == C_ADDR_WIDTH'(i));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg <= '0;
                    r_upd <= 1'b0;
                end else begin
                    r_upd <= w_hit;
                    if (w_hit) r_reg <= w_head_data;
                end
            end

            assign cfg_regs[i*C_DATA_WIDTH +: C_DATA_WIDTH] = r_reg;
            assign cfg_update[i]                            = r_upd;
        end
    endgenerate

`ifdef CONF_READBACK_EN
    logic [C_DATA_WIDTH-1:0] w_rd_mux;

    // Out-of-range addresses match no register and fall through to zero
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == C_ADDR_WIDTH'(i))
                w_rd_mux = cfg_regs[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= w_rd_mux;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conf_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conf_reg_bank                                             |
// | Description : Self-checking bench for conf_reg_bank: queue-based model     |
// |               compared every cycle plus directed literal expectations.     |
// |               Readback checks compile in when CONF_READBACK_EN is defined. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conf_reg_bank;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_data;
    logic            c_valid;
    logic            c_ready;
    logic            cfg_lock;
    logic            err_clr;
    logic [NR*DW-1:0] cfg_regs;
    logic [NR-1:0]   cfg_update;
    logic            c_err;
`ifdef CONF_READBACK_EN
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
`endif

    conf_reg_bank #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .NUM_REGS     (NR),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .cfg_lock   (cfg_lock),
        .err_clr    (err_clr),
        .cfg_regs   (cfg_regs),
        .cfg_update (cfg_update),
        .c_err      (c_err)
`ifdef CONF_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of pending writes and an array of registers
    bit [AW+DW-1:0] m_q[$];
    logic [DW-1:0]  m_regs [NR];
    logic [NR-1:0]  m_upd = '0;
    logic           m_err = 1'b0;
    logic [DW-1:0]  m_rd  = '0;

    initial for (int i = 0; i < NR; i++) m_regs[i] = '0;

    always @(posedge clk) begin
        int          a;
        logic [DW-1:0] d;
        bit          room;
        bit          new_err;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_upd = '0;
            m_err = 1'b0;
            m_rd  = '0;
        end else begin
            room    = (m_q.size() < FD);
            new_err = 1'b0;
`ifdef CONF_READBACK_EN
            m_rd = (int'(rd_addr) < NR) ? m_regs[int'(rd_addr)] : '0;
`endif
            m_upd = '0;
            if (m_q.size() > 0 && !cfg_lock) begin
                a = int'(m_q[0][AW+DW-1:DW]);
                d = m_q[0][DW-1:0];
                void'(m_q.pop_front());
                if (a < NR) begin
                    m_regs[a] = d;
                    m_upd     = NR'(1) << a;
                end else begin
                    new_err = 1'b1;
                end
            end
            if (new_err)      m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (c_valid && room) m_q.push_back({c_addr, c_data});
        end
    end

    always @(negedge clk) begin
        logic [NR*DW-1:0] flat;
        if (chk_en) begin
            for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m_regs[i];
            check("c_ready",    512'(c_ready),    512'(!rst && (m_q.size() != FD)));
            check("cfg_regs",   512'(cfg_regs),   512'(flat));
            check("cfg_update", 512'(cfg_update), 512'(m_upd));
            check("c_err",      512'(c_err),      512'(m_err));
`ifdef CONF_READBACK_EN
            check("rd_data",    512'(rd_data),    512'(m_rd));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return cfg_regs[i*DW +: DW];
    endfunction

    logic [NR-1:0] seen;
    int            pulses;

    initial begin
        rst = 1'b1; c_addr = '0; c_data = '0; c_valid = 1'b0;
        cfg_lock = 1'b0; err_clr = 1'b0;
`ifdef CONF_READBACK_EN
        rd_addr = '0;
`endif
        tick();
        chk_en = 1'b1;
        check("rst_ready", 512'(c_ready), 512'(0));
        check("rst_regs",  512'(cfg_regs), 512'(0));
        check("rst_err",   512'(c_err), 512'(0));
        tick();
        rst = 1'b0;
        #1 check("ready_after_rst", 512'(c_ready), 512'(1));

        // Single write to reg 3
        c_valid = 1'b1; c_addr = 8'd3; c_data = 32'hDEADBEEF;
        tick();
        c_valid = 1'b0;
        tick();
        check("t1_reg3", 512'(reg_of(3)), 512'(32'hDEADBEEF));
        check("t1_upd",  512'(cfg_update), 512'(16'h0008));
        check("t1_err",  512'(c_err), 512'(0));
        tick();
        check("t1_upd_off", 512'(cfg_update), 512'(0));
`ifdef CONF_READBACK_EN
        rd_addr = 8'd3;
        tick();
        check("rb_reg3", 512'(rd_data), 512'(32'hDEADBEEF));
        rd_addr = 8'h40;
        tick();
        check("rb_oor", 512'(rd_data), 512'(0));
`endif

        // Locked: five back-to-back writes, only four fit
        cfg_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_valid = 1'b1; c_addr = AW'(i); c_data = 32'h100 + i;
            #1 check("lock_ready", 512'(c_ready), 512'(i < 4));
            tick();
        end
        check("lock_no_upd", 512'(cfg_update), 512'(0));
        cfg_lock = 1'b0;
        tick();
        check("unlock_upd0", 512'(cfg_update), 512'(16'h0001));
        check("unlock_reg0", 512'(reg_of(0)), 512'(32'h100));
        check("unlock_ready", 512'(c_ready), 512'(1));
        tick();
        c_valid = 1'b0;
        check("unlock_upd1", 512'(cfg_update), 512'(16'h0002));
        tick(); check("unlock_upd2", 512'(cfg_update), 512'(16'h0004));
        tick(); check("unlock_upd3", 512'(cfg_update), 512'(16'h0008));
        check("unlock_reg3", 512'(reg_of(3)), 512'(32'h103));
        tick(); check("unlock_upd4", 512'(cfg_update), 512'(16'h0010));
        check("unlock_reg4", 512'(reg_of(4)), 512'(32'h104));
        tick(); check("unlock_idle", 512'(cfg_update), 512'(0));

        // Out-of-range write and sticky error
        c_valid = 1'b1; c_addr = 8'd20; c_data = 32'h0BAD;
        tick();
        c_valid = 1'b0;
        tick();
        check("oor_err", 512'(c_err), 512'(1));
        check("oor_upd", 512'(cfg_update), 512'(0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("oor_clr", 512'(c_err), 512'(0));
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("oor_set_wins", 512'(c_err), 512'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("oor_clr2", 512'(c_err), 512'(0));

        // Streaming writes to all registers
        seen = '0; pulses = 0;
        for (int i = 0; i < NR; i++) begin
            c_valid = 1'b1; c_addr = AW'(i); c_data = 32'hA000_0000 + i;
            #1 check("stream_ready", 512'(c_ready), 512'(1));
            tick();
            seen |= cfg_update; pulses += $countones(cfg_update);
        end
        c_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen |= cfg_update; pulses += $countones(cfg_update);
        end
        check("stream_seen",   512'(seen), 512'(16'hFFFF));
        check("stream_pulses", 512'(pulses), 512'(16));
        check("stream_reg15",  512'(reg_of(15)), 512'(32'hA000_000F));

        // Same register twice: last write wins
        c_valid = 1'b1; c_addr = 8'd5; c_data = 32'h1111_1111;
        tick();
        c_data = 32'h2222_2222;
        tick();
        c_valid = 1'b0;
        tick();
        check("twice_reg5", 512'(reg_of(5)), 512'(32'h2222_2222));
        check("twice_upd",  512'(cfg_update), 512'(16'h0020));

        // Reset with three entries queued
        cfg_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_valid = 1'b1; c_addr = AW'(7 + i); c_data = 32'h5500 + i;
            tick();
        end
        c_valid = 1'b0; cfg_lock = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_regs", 512'(cfg_regs), 512'(0));
        #1 check("rst2_ready", 512'(c_ready), 512'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst2_no_upd", 512'(cfg_update), 512'(0));
        end

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
